operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read-side companion of the register file. Accepts decoded instructions over a valid/ready handshake and drives the register file's two read addresses.
- Bypasses same-cycle writeback data and tracks pending destination writes in a scoreboard, stalling on hazards.
- Delivers registered operands to the execute stage over a second valid/ready handshake.
- Sits between decode and execute; snoops the writeback port that feeds the register file.

Parameters:
- REG_ADDR_WIDTH, 4, register address width; NUM_REGS = 1 << REG_ADDR_WIDTH.
- DATA_WIDTH, 8, operand width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- in_rs1  in  REG_ADDR_WIDTH  source register 1.
- in_rs2  in  REG_ADDR_WIDTH  source register 2.
- in_rd  in  REG_ADDR_WIDTH  destination register.
- in_rd_en  in  1  instruction writes in_rd.
- reg1  out  REG_ADDR_WIDTH  register file read address 1, equal to in_rs1 (combinational).
- reg2  out  REG_ADDR_WIDTH  register file read address 2, equal to in_rs2 (combinational).
- data1  in  DATA_WIDTH  register file read data 1, combinational.
- data2  in  DATA_WIDTH  register file read data 2, combinational.
- wb_en  in  1  writeback strobe, same signal as the register file write_en.
- wb_addr  in  REG_ADDR_WIDTH  writeback register, same as regw.
- wb_data  in  DATA_WIDTH  writeback data, same as dataw.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_op1  out  DATA_WIDTH  operand 1.
- out_op2  out  DATA_WIDTH  operand 2.
- out_rd  out  REG_ADDR_WIDTH  destination passthrough.
- out_rd_en  out  1  destination enable passthrough.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_en=0, all scoreboard busy bits cleared.
  - Reset mid-operation discards any held bundle and all pending-write tracking.
  - in_ready is 0 while rst=1.
- Scoreboard: busy[NUM_REGS-1:0].
  - Set busy[in_rd] on accept when in_rd_en=1.
  - Clear busy[wb_addr] when wb_en=1.
  - Same register set and cleared in the same cycle: set wins.
- Operand select, per source s: if wb_en && wb_addr==rs_s, use wb_data (bypass); else use data_s. The register file updates only at the edge, so the bypass is mandatory.
- Hazard (combinational):
  - raw1 = busy[in_rs1] && !(wb_en && wb_addr==in_rs1); raw2 likewise for in_rs2.
  - waw = in_rd_en && busy[in_rd] && !(wb_en && wb_addr==in_rd).
  - stall = raw1 || raw2 || waw.
- Output slot has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
  - can_load = !out_valid || out_ready.
  - in_ready = can_load && !stall.
  - Accept: bundle registered, out_valid=1 next cycle. Latency is exactly 1 cycle from accept to out_valid.
  - FULL && out_ready && no accept: go to EMPTY.
  - FULL && !out_ready: hold all out_* stable.
  - Back-to-back accept while draining is allowed: full throughput of 1 per cycle with no hazards.
- rs1==rs2: both operands take the same value. rd equal to rs1 or rs2 is legal: the read uses the old value, then busy[rd] is set.
- Writes land in order per register; the WAW stall guarantees at most one pending write per register.
- wb_en to a non-busy register (e.g. writes from outside this pipe): clear is a no-op, and the bypass still applies.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams REG_ADDR_WIDTH, DATA_WIDTH, NUM_REGS;
  - typedef reg_addr_t (logic [REG_ADDR_WIDTH-1:0]);
  - typedef data_t;
  - struct operand_bundle_t {op1, op2, rd, rd_en}.
- One natural sub-module: scoreboard. It holds the busy vector with set/clear ports and exposes busy bits for the hazard logic. Bypass muxes and the output slot stay in operand_fetch.

Test Plan:
- Reset then idle: out_valid=0, in_ready=1, busy all 0. Accept rs1=2, rs2=3 with data1=0x11, data2=0x22 -> next cycle out_op1=0x11, out_op2=0x22, out_valid=1.
- Bypass: wb_en=1, wb_addr=5, wb_data=0xA5 in the same cycle as an accept with rs1=5, data1=0x00 -> out_op1=0xA5.
- RAW stall: accept rd=4, rd_en=1, then next instruction rs2=4 -> in_ready=0 until wb_en/wb_addr=4/wb_data=0x3C. In that cycle in_ready=1 and out_op2=0x3C; busy[4] clears.
- WAW plus simultaneous set/clear: pending rd=7 and new rd=7 -> stall. On the wb cycle to 7 the new instruction is accepted and busy[7] stays 1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0. Raise out_ready -> the next bundle loads the same cycle and out_valid stays 1.
- Reset mid-operation: busy[9]=1 and out_valid=1, assert rst one cycle -> out_valid=0, busy cleared; an instruction with rs1=9 is accepted immediately.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// Shared CPU types for the operand-fetch stage: register/data widths,
// the operand bundle handed to execute, and the output-slot state encoding.
package cpu_pkg;

  localparam int unsigned REG_ADDR_WIDTH = 4;
  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  typedef struct packed {
    data_t     op1;
    data_t     op2;
    reg_addr_t rd;
    logic      rd_en;
  } operand_bundle_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

  // True when the writeback port is writing register addr this cycle.
  function automatic logic wb_hits(input logic en, input reg_addr_t wb_addr, input reg_addr_t addr);
    return en && (wb_addr == addr);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Bus bundle around operand_fetch: decode handshake, register-file read port,
// writeback snoop and execute handshake.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic      in_valid;
  logic      in_ready;
  reg_addr_t in_rs1;
  reg_addr_t in_rs2;
  reg_addr_t in_rd;
  logic      in_rd_en;

  reg_addr_t reg1;
  reg_addr_t reg2;
  data_t     data1;
  data_t     data2;

  logic      wb_en;
  reg_addr_t wb_addr;
  data_t     wb_data;

  logic      out_valid;
  logic      out_ready;
  data_t     out_op1;
  data_t     out_op2;
  reg_addr_t out_rd;
  logic      out_rd_en;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en,
    input  data1, data2,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, reg1, reg2,
    output out_valid, out_op1, out_op2, out_rd, out_rd_en
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_en,
    output data1, data2,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, reg1, reg2,
    input  out_valid, out_op1, out_op2, out_rd, out_rd_en
  );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write tracker: one busy bit per register, set on issue, cleared on
// writeback; a simultaneous set and clear of the same register leaves it busy.
module operand_fetch_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  reg_addr_t           set_addr_i,
  input  logic                clr_en_i,
  input  reg_addr_t           clr_addr_i,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clear first so a same-cycle set of the same register takes priority.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      busy_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads the register file, bypasses same-cycle writeback,
// stalls on RAW/WAW hazards and holds one registered bundle for execute.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus
);

  logic [NUM_REGS-1:0] busy;
  logic                wb_hit1;
  logic                wb_hit2;
  logic                wb_hit_rd;
  logic                raw1;
  logic                raw2;
  logic                waw;
  logic                stall;
  logic                can_load;
  logic                ready;
  logic                accept;
  data_t               op1_sel;
  data_t               op2_sel;

  slot_state_e         state_q;
  slot_state_e         state_d;
  operand_bundle_t     bundle_q;
  operand_bundle_t     bundle_d;

  assign bus.reg1 = bus.in_rs1;
  assign bus.reg2 = bus.in_rs2;

  // The register file only updates at the edge, so a same-cycle write must be forwarded.
  assign wb_hit1   = wb_hits(bus.wb_en, bus.wb_addr, bus.in_rs1);
  assign wb_hit2   = wb_hits(bus.wb_en, bus.wb_addr, bus.in_rs2);
  assign wb_hit_rd = wb_hits(bus.wb_en, bus.wb_addr, bus.in_rd);

  assign op1_sel = wb_hit1 ? bus.wb_data : bus.data1;
  assign op2_sel = wb_hit2 ? bus.wb_data : bus.data2;

  // A pending write that is landing this cycle no longer blocks.
  assign raw1  = busy[bus.in_rs1] && !wb_hit1;
  assign raw2  = busy[bus.in_rs2] && !wb_hit2;
  assign waw   = bus.in_rd_en && busy[bus.in_rd] && !wb_hit_rd;
  assign stall = raw1 || raw2 || waw;

  assign can_load = (state_q == ST_EMPTY) || bus.out_ready;
  assign ready    = !rst && can_load && !stall;
  assign accept   = bus.in_valid && ready;

  assign bus.in_ready = ready;

  operand_fetch_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (accept && bus.in_rd_en),
    .set_addr_i (bus.in_rd),
    .clr_en_i   (bus.wb_en),
    .clr_addr_i (bus.wb_addr),
    .busy_o     (busy)
  );

  // Output slot: loads on accept, drains when execute takes the bundle.
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept) begin
          state_d = ST_FULL;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept) begin
      bundle_d.op1   = op1_sel;
      bundle_d.op2   = op2_sel;
      bundle_d.rd    = bus.in_rd;
      bundle_d.rd_en = bus.in_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      bundle_q <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_op1   = bundle_q.op1;
  assign bus.out_op2   = bundle_q.op2;
  assign bus.out_rd    = bundle_q.rd;
  assign bus.out_rd_en = bundle_q.rd_en;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: stimulus queues expected bundles, a
// monitor pops and compares each bundle execute accepts.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  operand_bundle_t exp_q[$];
  operand_bundle_t mon_exp;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every bundle execute takes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_bundle", 32'(bus.out_op1), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_op1",   32'(bus.out_op1),   32'(mon_exp.op1));
        check("out_op2",   32'(bus.out_op2),   32'(mon_exp.op2));
        check("out_rd",    32'(bus.out_rd),    32'(mon_exp.rd));
        check("out_rd_en", 32'(bus.out_rd_en), 32'(mon_exp.rd_en));
      end
    end
  end

  task automatic send(input reg_addr_t rs1, input reg_addr_t rs2, input reg_addr_t rd,
                      input logic rd_en, input data_t d1, input data_t d2,
                      input data_t e1, input data_t e2, input int max_wait);
    int waited;
    operand_bundle_t e;
    waited       = 0;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_rd_en = rd_en;
    bus.data1    = d1;
    bus.data2    = d2;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > max_wait) begin
        check("accept_timeout", 32'(waited), 32'(max_wait));
        bus.in_valid = 1'b0;
        return;
      end
    end
    check("reg1", 32'(bus.reg1), 32'(rs1));
    check("reg2", 32'(bus.reg2), 32'(rs2));
    e.op1 = e1; e.op2 = e2; e.rd = rd; e.rd_en = rd_en;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("latency_valid", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic push_exp(input data_t e1, input data_t e2, input reg_addr_t rd, input logic rd_en);
    operand_bundle_t e;
    e.op1 = e1; e.op2 = e2; e.rd = rd; e.rd_en = rd_en;
    exp_q.push_back(e);
  endtask

  task automatic wb_cycle(input reg_addr_t a, input data_t d);
    bus.wb_en = 1'b1; bus.wb_addr = a; bus.wb_data = d;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_rd_en = 1'b0;
    bus.data1 = '0; bus.data2 = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    check("out_valid_in_reset", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_busy", 32'(dut.u_sb.busy_q), 32'd0);
    check("idle_out_op1", 32'(bus.out_op1), 32'd0);
    @(posedge clk); #1;

    // Basic read, then back-to-back bypassed read.
    send(4'd2, 4'd3, 4'd1, 1'b0, 8'h11, 8'h22, 8'h11, 8'h22, 0);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 8'hA5;
    send(4'd5, 4'd6, 4'd0, 1'b0, 8'h00, 8'h66, 8'hA5, 8'h66, 0);
    bus.wb_en = 1'b0;

    // RAW on rs2 released by writeback with forwarded data.
    send(4'd0, 4'd0, 4'd4, 1'b1, 8'h01, 8'h02, 8'h01, 8'h02, 0);
    check("busy4_set", 32'(dut.u_sb.busy_q[4]), 32'd1);
    bus.in_rs1 = 4'd1; bus.in_rs2 = 4'd4; bus.in_rd = 4'd2; bus.in_rd_en = 1'b1;
    bus.data1 = 8'h55; bus.data2 = 8'h99; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("raw_stall", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd4; bus.wb_data = 8'h3C;
    @(negedge clk);
    check("raw_release", 32'(bus.in_ready), 32'd1);
    push_exp(8'h55, 8'h3C, 4'd2, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    check("busy4_clear", 32'(dut.u_sb.busy_q[4]), 32'd0);
    check("busy2_set", 32'(dut.u_sb.busy_q[2]), 32'd1);
    wb_cycle(4'd2, 8'h00);
    check("busy_after_raw", 32'(dut.u_sb.busy_q), 32'd0);

    // WAW on rd=7 with same-cycle set and clear.
    send(4'd0, 4'd0, 4'd7, 1'b1, 8'h70, 8'h71, 8'h70, 8'h71, 0);
    bus.in_rs1 = 4'd1; bus.in_rs2 = 4'd2; bus.in_rd = 4'd7; bus.in_rd_en = 1'b1;
    bus.data1 = 8'h0A; bus.data2 = 8'h0B; bus.in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("waw_stall", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd7; bus.wb_data = 8'hEE;
    @(negedge clk);
    check("waw_release", 32'(bus.in_ready), 32'd1);
    push_exp(8'h0A, 8'h0B, 4'd7, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.wb_en = 1'b0;
    check("busy7_set_wins", 32'(dut.u_sb.busy_q[7]), 32'd1);
    wb_cycle(4'd7, 8'hEF);
    check("busy_after_waw", 32'(dut.u_sb.busy_q), 32'd0);

    // Backpressure: slot holds, then reloads in the draining cycle.
    bus.out_ready = 1'b0;
    send(4'd1, 4'd2, 4'd3, 1'b1, 8'h31, 8'h32, 8'h31, 8'h32, 0);
    bus.in_rs1 = 4'd4; bus.in_rs2 = 4'd5; bus.in_rd = 4'd6; bus.in_rd_en = 1'b1;
    bus.data1 = 8'h41; bus.data2 = 8'h42; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_op1", 32'(bus.out_op1), 32'h31);
      check("bp_op2", 32'(bus.out_op2), 32'h32);
      check("bp_rd", 32'(bus.out_rd), 32'd3);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(bus.in_ready), 32'd1);
    push_exp(8'h41, 8'h42, 4'd6, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_valid_stays", 32'(bus.out_valid), 32'd1);
    check("bp_new_op1", 32'(bus.out_op1), 32'h41);
    @(posedge clk); #1;

    // Reset mid-operation drops the held bundle and pending writes.
    bus.out_ready = 1'b0;
    send(4'd0, 4'd0, 4'd9, 1'b1, 8'h90, 8'h91, 8'h90, 8'h91, 0);
    check("busy9_set", 32'(dut.u_sb.busy_q[9]), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(dut.u_sb.busy_q), 32'd0);
    check("rst_out_op1", 32'(bus.out_op1), 32'd0);
    check("rst_out_op2", 32'(bus.out_op2), 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_out_rd_en", 32'(bus.out_rd_en), 32'd0);
    bus.out_ready = 1'b1;
    send(4'd9, 4'd3, 4'd0, 1'b0, 8'h99, 8'h33, 8'h99, 8'h33, 0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
